// File: rtl/reset_sequencer.sv
// Reset sequencer: waits for the video MMCM, MIG MMCM and DDR calibration
// locks, requires them to stay stable, then releases the global/peripheral
// reset first and the CPU reset PERIPH_DELAY cycles later.
// Optional feature: define RESET_SEQ_MIG_RETRY_EN to add a lock-wait timeout
// that pulses mig_sys_rst and counts retries (saturating at 15).
module reset_sequencer #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned STABLE_CYCLES  = 1024,
  parameter int unsigned PERIPH_DELAY   = 16,
  parameter int unsigned TIMEOUT_CYCLES = 2**20,
  parameter int unsigned RETRY_PULSE    = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       video_mode_locked,
  input  logic       mig_mmcm_locked,
  input  logic       mig_init_calib_complete,
  output logic       hard_resetn,
  output logic       periph_reset,
  output logic       cpu_resetn,
  output logic       mig_sys_rst,
  output logic [2:0] seq_state,
  output logic [3:0] retry_count
);

  localparam int unsigned ST_W = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned PD_W = $clog2(PERIPH_DELAY + 1);

  localparam logic [2:0] S_RESET      = 3'd0;
  localparam logic [2:0] S_WAIT_LOCK  = 3'd1;
  localparam logic [2:0] S_STABLE     = 3'd2;
  localparam logic [2:0] S_REL_PERIPH = 3'd3;
  localparam logic [2:0] S_RUN        = 3'd4;
`ifdef RESET_SEQ_MIG_RETRY_EN
  localparam logic [2:0] S_RETRY      = 3'd5;
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned RP_W = $clog2(RETRY_PULSE + 1);
`endif

  logic [SYNC_STAGES-1:0] sync_video;
  logic [SYNC_STAGES-1:0] sync_mmcm;
  logic [SYNC_STAGES-1:0] sync_calib;
  logic                   all_locked_s;

  logic [2:0]      state;
  logic [2:0]      state_nxt;
  logic [ST_W-1:0] stab_cnt;
  logic [ST_W-1:0] stab_nxt;
  logic [PD_W-1:0] per_cnt;
  logic [PD_W-1:0] per_nxt;

`ifdef RESET_SEQ_MIG_RETRY_EN
  logic [TO_W-1:0] to_cnt;
  logic [TO_W-1:0] to_nxt;
  logic [RP_W-1:0] pulse_cnt;
  logic [RP_W-1:0] pulse_nxt;
  logic [3:0]      retry_nxt;
  logic            to_hit;

  assign to_hit = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`endif

  assign all_locked_s = sync_video[SYNC_STAGES-1] & sync_mmcm[SYNC_STAGES-1]
                      & sync_calib[SYNC_STAGES-1];
  assign seq_state    = state;

  // Per-input multi-flop synchronizers for the asynchronous lock signals
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_video <= '0;
      sync_mmcm  <= '0;
      sync_calib <= '0;
    end else begin
      sync_video <= {sync_video[SYNC_STAGES-2:0], video_mode_locked};
      sync_mmcm  <= {sync_mmcm[SYNC_STAGES-2:0], mig_mmcm_locked};
      sync_calib <= {sync_calib[SYNC_STAGES-2:0], mig_init_calib_complete};
    end
  end

  // Next-state and counter logic; timeout overrides any same-cycle progress
  always_comb begin
    state_nxt = state;
    stab_nxt  = stab_cnt;
    per_nxt   = per_cnt;
`ifdef RESET_SEQ_MIG_RETRY_EN
    to_nxt    = to_cnt;
    pulse_nxt = pulse_cnt;
    retry_nxt = retry_count;
`endif
    case (state)
      S_RESET: state_nxt = S_WAIT_LOCK;
      S_WAIT_LOCK: begin
        if (all_locked_s) begin
          state_nxt = S_STABLE;
          stab_nxt  = '0;
        end
      end
      S_STABLE: begin
        if (!all_locked_s) begin
          state_nxt = S_WAIT_LOCK;
        end else if (stab_cnt == ST_W'(STABLE_CYCLES - 1)) begin
          state_nxt = S_REL_PERIPH;
          per_nxt   = '0;
        end else begin
          stab_nxt = stab_cnt + ST_W'(1);
        end
      end
      S_REL_PERIPH: begin
        if (!all_locked_s) begin
          state_nxt = S_WAIT_LOCK;
        end else if (per_cnt == PD_W'(PERIPH_DELAY - 1)) begin
          state_nxt = S_RUN;
        end else begin
          per_nxt = per_cnt + PD_W'(1);
        end
      end
      S_RUN: begin
        if (!all_locked_s) state_nxt = S_WAIT_LOCK;
      end
`ifdef RESET_SEQ_MIG_RETRY_EN
      S_RETRY: begin
        if (pulse_cnt == RP_W'(RETRY_PULSE - 1)) begin
          state_nxt = S_WAIT_LOCK;
        end else begin
          pulse_nxt = pulse_cnt + RP_W'(1);
        end
      end
`endif
      default: state_nxt = S_RESET;
    endcase
`ifdef RESET_SEQ_MIG_RETRY_EN
    // Lock-wait timeout runs across WAIT_LOCK and STABLE
    if ((state == S_WAIT_LOCK) || (state == S_STABLE)) begin
      if (to_hit) begin
        state_nxt = S_RETRY;
        stab_nxt  = stab_cnt;
        pulse_nxt = '0;
        retry_nxt = (retry_count == 4'hF) ? 4'hF : retry_count + 4'd1;
      end else begin
        to_nxt = to_cnt + TO_W'(1);
      end
    end
    // Fresh timeout window on entry to WAIT_LOCK from outside the wait loop
    if ((state_nxt == S_WAIT_LOCK) && (state != S_WAIT_LOCK) && (state != S_STABLE)) begin
      to_nxt = '0;
    end
`endif
  end

  // State, counter and registered output update
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_RESET;
      stab_cnt     <= '0;
      per_cnt      <= '0;
      hard_resetn  <= 1'b0;
      periph_reset <= 1'b1;
      cpu_resetn   <= 1'b0;
    end else begin
      state        <= state_nxt;
      stab_cnt     <= stab_nxt;
      per_cnt      <= per_nxt;
      hard_resetn  <= (state_nxt == S_REL_PERIPH) || (state_nxt == S_RUN);
      periph_reset <= !((state_nxt == S_REL_PERIPH) || (state_nxt == S_RUN));
      cpu_resetn   <= (state_nxt == S_RUN);
    end
  end

`ifdef RESET_SEQ_MIG_RETRY_EN
  // Retry machinery: timeout, pulse width, retry count and MIG reset pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt      <= '0;
      pulse_cnt   <= '0;
      retry_count <= 4'd0;
      mig_sys_rst <= 1'b0;
    end else begin
      to_cnt      <= to_nxt;
      pulse_cnt   <= pulse_nxt;
      retry_count <= retry_nxt;
      mig_sys_rst <= (state_nxt == S_RETRY);
    end
  end
`else
  assign mig_sys_rst = 1'b0;
  assign retry_count = 4'd0;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed testbench for reset_sequencer (SYNC_STAGES=2, STABLE_CYCLES=8,
// PERIPH_DELAY=4, TIMEOUT_CYCLES=64, RETRY_PULSE=3). Edge 0 is the first
// edge with reset low; lock inputs are driven just after that edge.
module tb_reset_sequencer;
  localparam int unsigned SS = 2;
  localparam int unsigned SC = 8;
  localparam int unsigned PD = 4;
  localparam int unsigned TO = 64;
  localparam int unsigned RP = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       video = 1'b0;
  logic       mmcm = 1'b0;
  logic       calib = 1'b0;
  logic       hard_resetn;
  logic       periph_reset;
  logic       cpu_resetn;
  logic       mig_sys_rst;
  logic [2:0] seq_state;
  logic [3:0] retry_count;

  int total = 0;
  int bad = 0;
  bit mig_seen = 1'b0;

  always #5 clk = ~clk;

  reset_sequencer #(
    .SYNC_STAGES(SS), .STABLE_CYCLES(SC), .PERIPH_DELAY(PD),
    .TIMEOUT_CYCLES(TO), .RETRY_PULSE(RP)
  ) dut (
    .clk(clk), .reset(reset),
    .video_mode_locked(video), .mig_mmcm_locked(mmcm),
    .mig_init_calib_complete(calib),
    .hard_resetn(hard_resetn), .periph_reset(periph_reset),
    .cpu_resetn(cpu_resetn), .mig_sys_rst(mig_sys_rst),
    .seq_state(seq_state), .retry_count(retry_count)
  );

  // Track any assertion of the MIG retry pulse
  always @(negedge clk) if (mig_sys_rst === 1'b1) mig_seen = 1'b1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold reset with locks low, release it, and stop just after edge 0
  task automatic start_seq();
    reset = 1'b1; video = 1'b0; mmcm = 1'b0; calib = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; video = 1'b1; mmcm = 1'b1; calib = 1'b1;
    repeat (3) tick();
    total++; if (seq_state !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", seq_state); end
    total++; if (hard_resetn !== 1'b0) begin bad++; $display("FAIL reset_hard got=%b exp=0", hard_resetn); end
    total++; if (periph_reset !== 1'b1) begin bad++; $display("FAIL reset_periph got=%b exp=1", periph_reset); end
    total++; if (cpu_resetn !== 1'b0) begin bad++; $display("FAIL reset_cpu got=%b exp=0", cpu_resetn); end
    total++; if (mig_sys_rst !== 1'b0) begin bad++; $display("FAIL reset_mig got=%b exp=0", mig_sys_rst); end
    total++; if (retry_count !== 4'd0) begin bad++; $display("FAIL reset_retry got=%0d exp=0", retry_count); end
    reset = 1'b0;
    tick();
    total++; if (seq_state !== 3'd1) begin bad++; $display("FAIL reset_exit got=%0d exp=1", seq_state); end
  endtask

  task automatic test_release();
    start_seq();
    video = 1'b1; mmcm = 1'b1; calib = 1'b1;
    for (int e = 1; e <= 16; e++) begin
      tick();
      if (e == 3) begin
        total++; if (seq_state !== 3'd2) begin bad++; $display("FAIL rel_stable e=%0d got=%0d exp=2", e, seq_state); end
      end
      total++; if (hard_resetn !== (e >= 11)) begin bad++; $display("FAIL rel_hard e=%0d got=%b exp=%b", e, hard_resetn, e >= 11); end
      total++; if (periph_reset !== (e < 11)) begin bad++; $display("FAIL rel_periph e=%0d got=%b exp=%b", e, periph_reset, e < 11); end
      total++; if (cpu_resetn !== (e >= 15)) begin bad++; $display("FAIL rel_cpu e=%0d got=%b exp=%b", e, cpu_resetn, e >= 15); end
    end
    total++; if (seq_state !== 3'd4) begin bad++; $display("FAIL rel_run got=%0d exp=4", seq_state); end
  endtask

  task automatic test_run_drop();
    video = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      tick();
      if (e < 3) begin
        total++; if (hard_resetn !== 1'b1) begin bad++; $display("FAIL drop_early e=%0d got=%b exp=1", e, hard_resetn); end
      end
    end
    total++; if (seq_state !== 3'd1) begin bad++; $display("FAIL drop_state got=%0d exp=1", seq_state); end
    total++; if (hard_resetn !== 1'b0) begin bad++; $display("FAIL drop_hard got=%b exp=0", hard_resetn); end
    total++; if (periph_reset !== 1'b1) begin bad++; $display("FAIL drop_periph got=%b exp=1", periph_reset); end
    total++; if (cpu_resetn !== 1'b0) begin bad++; $display("FAIL drop_cpu got=%b exp=0", cpu_resetn); end
    video = 1'b1;
    for (int f = 1; f <= 16; f++) begin
      tick();
      total++; if (hard_resetn !== (f >= 11)) begin bad++; $display("FAIL relock_hard f=%0d got=%b exp=%b", f, hard_resetn, f >= 11); end
      total++; if (cpu_resetn !== (f >= 15)) begin bad++; $display("FAIL relock_cpu f=%0d got=%b exp=%b", f, cpu_resetn, f >= 15); end
    end
    total++; if (seq_state !== 3'd4) begin bad++; $display("FAIL relock_run got=%0d exp=4", seq_state); end
  endtask

  // Calibration glitch late in the window must restart the full window
  task automatic test_glitch();
    start_seq();
    video = 1'b1; mmcm = 1'b1; calib = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      tick();
      if (e == 8) calib = 1'b0;
      if (e == 9) calib = 1'b1;
      if (e == 11) begin
        total++; if (seq_state !== 3'd1) begin bad++; $display("FAIL glitch_wait got=%0d exp=1", seq_state); end
      end
      if (e == 12) begin
        total++; if (seq_state !== 3'd2) begin bad++; $display("FAIL glitch_restable got=%0d exp=2", seq_state); end
      end
      total++; if (hard_resetn !== (e >= 20)) begin bad++; $display("FAIL glitch_hard e=%0d got=%b exp=%b", e, hard_resetn, e >= 20); end
    end
  endtask

  task automatic check_reset_values(input string tag);
    total++; if (seq_state !== 3'd0) begin bad++; $display("FAIL %s_state got=%0d exp=0", tag, seq_state); end
    total++; if (hard_resetn !== 1'b0) begin bad++; $display("FAIL %s_hard got=%b exp=0", tag, hard_resetn); end
    total++; if (periph_reset !== 1'b1) begin bad++; $display("FAIL %s_periph got=%b exp=1", tag, periph_reset); end
    total++; if (cpu_resetn !== 1'b0) begin bad++; $display("FAIL %s_cpu got=%b exp=0", tag, cpu_resetn); end
    total++; if (mig_sys_rst !== 1'b0) begin bad++; $display("FAIL %s_mig got=%b exp=0", tag, mig_sys_rst); end
    total++; if (retry_count !== 4'd0) begin bad++; $display("FAIL %s_retry got=%0d exp=0", tag, retry_count); end
  endtask

  task automatic test_reset_in_run();
    start_seq();
    video = 1'b1; mmcm = 1'b1; calib = 1'b1;
    repeat (16) tick();
    total++; if (seq_state !== 3'd4) begin bad++; $display("FAIL rrun_pre got=%0d exp=4", seq_state); end
    reset = 1'b1;
    tick();
    check_reset_values("rrun");
    reset = 1'b0;
    tick();
    total++; if (seq_state !== 3'd1) begin bad++; $display("FAIL rrun_exit got=%0d exp=1", seq_state); end
  endtask

`ifdef RESET_SEQ_MIG_RETRY_EN
  task automatic test_retry();
    int first;
    int highs;
    int rises;
    int cyc;
    bit prev;
    start_seq();
    video = 1'b1; mmcm = 1'b1; calib = 1'b0;
    first = -1; highs = 0;
    for (int e = 1; e <= 70; e++) begin
      tick();
      if (mig_sys_rst === 1'b1) begin
        if (first < 0) first = e;
        highs++;
      end
    end
    total++; if (first != 64) begin bad++; $display("FAIL retry_first got=%0d exp=64", first); end
    total++; if (highs != 3) begin bad++; $display("FAIL retry_width got=%0d exp=3", highs); end
    total++; if (retry_count !== 4'd1) begin bad++; $display("FAIL retry_cnt1 got=%0d exp=1", retry_count); end
    total++; if (seq_state !== 3'd1) begin bad++; $display("FAIL retry_back got=%0d exp=1", seq_state); end
    rises = 1; prev = mig_sys_rst; cyc = 0;
    while (rises < 20 && cyc < 2000) begin
      tick(); cyc++;
      if (mig_sys_rst === 1'b1 && !prev) begin
        rises++;
        if (rises == 2) begin
          total++; if (retry_count !== 4'd2) begin bad++; $display("FAIL retry_cnt2 got=%0d exp=2", retry_count); end
        end
      end
      prev = mig_sys_rst;
    end
    total++; if (rises != 20) begin bad++; $display("FAIL retry_bound got=%0d exp=20", rises); end
    total++; if (retry_count !== 4'd15) begin bad++; $display("FAIL retry_sat got=%0d exp=15", retry_count); end
    cyc = 0;
    while (mig_sys_rst !== 1'b1 && cyc < 200) begin tick(); cyc++; end
    total++; if (mig_sys_rst !== 1'b1) begin bad++; $display("FAIL retry_wait got=%b exp=1", mig_sys_rst); end
    reset = 1'b1;
    tick();
    check_reset_values("rretry");
    reset = 1'b0;
    calib = 1'b1;
    tick();
  endtask
`else
  task automatic test_no_retry();
    start_seq();
    video = 1'b1; mmcm = 1'b1; calib = 1'b0;
    repeat (150) tick();
    total++; if (seq_state !== 3'd1) begin bad++; $display("FAIL noretry_state got=%0d exp=1", seq_state); end
    total++; if (retry_count !== 4'd0) begin bad++; $display("FAIL noretry_cnt got=%0d exp=0", retry_count); end
    total++; if (mig_seen !== 1'b0) begin bad++; $display("FAIL noretry_mig got=%b exp=0", mig_seen); end
    calib = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_release();
    test_run_drop();
    test_glitch();
`ifdef RESET_SEQ_MIG_RETRY_EN
    test_retry();
`else
    test_no_retry();
`endif
    test_reset_in_run();
`ifndef RESET_SEQ_MIG_RETRY_EN
    total++; if (mig_seen !== 1'b0) begin bad++; $display("FAIL mig_never got=%b exp=0", mig_seen); end
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
